// File: rtl/pe_packet_router.sv
// pe_packet_router: steers one packet word per cycle from a valid/ready input
// port to either the ifmap channel (split into ifmap/conv_loc/size fields) or
// one of NROWS filter-row channels. Each channel owns a small show-ahead FIFO,
// so a stalled consumer only blocks words headed for its own channel.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_data             packet word (DATA_W)
//   in_is_filter        0 = ifmap word, 1 = filter word
//   in_row              filter row index 1..NROWS
//   ifmap_valid/ready   ifmap channel handshake
//   ifmap_data          top IFMAP_W bits of the stored word
//   conv_loc, size      remaining fields of the stored ifmap word
//   filt_valid/ready    per-row handshake, bit r-1 = row r
//   filt_data           per-row word, slice r-1 = row r
//   err_row             sticky: filter word with an invalid row was seen
//
// Build option: define PE_ROUTER_BCAST_EN to treat in_row = 0 as a broadcast
// to every row FIFO; otherwise in_row = 0 is an invalid row.
module pe_packet_router #(
  parameter int FILTER_WIDTH = 8,
  parameter int NROWS        = 5,
  parameter int IFMAP_W      = 25,
  parameter int DEPTH        = 2,
  localparam int DATA_W      = 5 * FILTER_WIDTH,
  localparam int ROW_W       = $clog2(NROWS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_is_filter,
  input  logic [ROW_W-1:0]            in_row,
  output logic                        ifmap_valid,
  input  logic                        ifmap_ready,
  output logic [IFMAP_W-1:0]          ifmap_data,
  output logic [DATA_W-IFMAP_W-3:0]   conv_loc,
  output logic [1:0]                  size,
  output logic [NROWS-1:0]            filt_valid,
  input  logic [NROWS-1:0]            filt_ready,
  output logic [NROWS*DATA_W-1:0]     filt_data,
  output logic                        err_row
);

  // Channel 0 is the ifmap FIFO, channel r (1..NROWS) is filter row r.
  localparam int NCH = NROWS + 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem  [NCH][DEPTH];
  logic [PW-1:0]     r_wptr [NCH];
  logic [PW-1:0]     r_rptr [NCH];
  logic [CW-1:0]     r_cnt  [NCH];
  logic              r_err;

  logic [NCH-1:0]    w_sel;
  logic [NCH-1:0]    w_full;
  logic [NCH-1:0]    w_valid;
  logic [NCH-1:0]    w_oready;
  logic [NCH-1:0]    w_push;
  logic [NCH-1:0]    w_pop;
  logic [DATA_W-1:0] w_head [NCH];
  logic              w_bcast;
  logic              w_row_ok;
  logic              w_fire;

`ifdef PE_ROUTER_BCAST_EN
  assign w_bcast = in_is_filter && (in_row == '0);
`else
  assign w_bcast = 1'b0;
`endif

  assign w_row_ok = (in_row != '0) && (in_row <= ROW_W'(NROWS));

  always_comb begin
    w_sel    = '0;
    w_oready = '0;
    w_sel[0]    = !in_is_filter;
    w_oready[0] = ifmap_ready;
    for (int unsigned c = 1; c < NCH; c++) begin
      w_sel[c]    = in_is_filter && ((in_row == ROW_W'(c)) || w_bcast);
      w_oready[c] = filt_ready[c-1];
    end
    for (int unsigned c = 0; c < NCH; c++) begin
      w_full[c]  = (r_cnt[c] == CW'(DEPTH));
      w_valid[c] = (r_cnt[c] != '0);
      w_head[c]  = r_mem[c][r_rptr[c]];
    end
  end

  // Readiness looks only at registered counts: a same-cycle pop never frees
  // room for a push into a full FIFO. An empty target set (invalid row) is
  // always ready so the word is consumed and dropped.
  assign in_ready = ~|(w_sel & w_full);
  assign w_fire   = in_valid && in_ready;
  assign w_push   = w_fire ? w_sel : '0;
  assign w_pop    = w_valid & w_oready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
        for (int unsigned d = 0; d < DEPTH; d++) begin
          r_mem[c][d] <= '0;
        end
      end
      r_err <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (w_push[c]) begin
          r_mem[c][r_wptr[c]] <= in_data;
          r_wptr[c]           <= r_wptr[c] + PW'(1);
        end
        if (w_pop[c]) begin
          r_rptr[c] <= r_rptr[c] + PW'(1);
        end
        case ({w_push[c], w_pop[c]})
          2'b10:   r_cnt[c] <= r_cnt[c] + CW'(1);
          2'b01:   r_cnt[c] <= r_cnt[c] - CW'(1);
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
      if (in_valid && in_is_filter && !w_row_ok && !w_bcast) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_row     = r_err;
  assign ifmap_valid = w_valid[0];
  assign ifmap_data  = w_head[0][DATA_W-1 -: IFMAP_W];
  assign conv_loc    = w_head[0][DATA_W-IFMAP_W-1:2];
  assign size        = w_head[0][1:0];

  always_comb begin
    filt_valid = '0;
    filt_data  = '0;
    for (int unsigned r = 0; r < NROWS; r++) begin
      filt_valid[r]                   = w_valid[r+1];
      filt_data[r*DATA_W +: DATA_W]   = w_head[r+1];
    end
  end

endmodule
